// File: rtl/seg7_reg_display_pkg.sv
// Shared definitions for the register 7-segment display: converter states,
// glyph constants and the hex glyph lookup.
package seg7_reg_display_pkg;

  // Five BCD digits cover any 16-bit operand (0..65535).
  localparam int BCD_W = 20;

  // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } bcd_state_e;

  // Standard hex glyphs; 'b' and 'd' are lowercase so they differ from '8' and '0'.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_reg_display_bin2bcd.sv
// Sequential shift-add-3 (double-dabble) binary to BCD converter.
// One start pulse in IDLE runs LOAD (1 cycle), SHIFT (DW cycles), DONE (1 cycle).
module seg7_reg_display_bin2bcd
  import seg7_reg_display_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [DW-1:0]    bin,
  output logic [BCD_W-1:0] bcd,
  output logic [DW-1:0]    op,
  output logic             done,
  output logic             busy
);

  localparam int SR_W  = BCD_W + DW;
  localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

  bcd_state_e       state_q, state_d;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    op_q;

  // Converter state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    done    = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(DW - 1)) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (sr_q[DW + 4*i +: 4] >= 4'd5)
        sr_adj[DW + 4*i +: 4] = sr_q[DW + 4*i +: 4] + 4'd3;
    end
  end

  // Datapath: capture the operand on LOAD, then adjust-and-shift once per SHIFT cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!RST_N) begin
      sr_q  <= '0;
      cnt_q <= '0;
      op_q  <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          op_q  <= bin;
          sr_q  <= {{BCD_W{1'b0}}, bin};
          cnt_q <= '0;
        end
        ST_SHIFT: begin
          sr_q  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = sr_q[SR_W-1:DW];
  assign op  = op_q;

endmodule

// File: rtl/seg7_reg_display.sv
// Shows the low DW bits of CPU register 2 or 3 on a 4-digit common-anode
// 7-segment display, in hex or in decimal with leading-zero blanking.
module seg7_reg_display
  import seg7_reg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DW          = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] reg_2,
  input  logic [31:0] reg_3,
  input  logic        sel_reg,
  input  logic        hex_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DW-1:0]    src;
  logic [DW-1:0]    op_q;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] dec_q;
  logic             conv_done;
  logic             conv_busy;
  logic             start;

  logic [RC_W-1:0]  refresh_q;
  logic [1:0]       idx_q;

  logic [15:0]      hex_val;
  logic [3:0]       blank_mask;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  // Only the low DW bits of each tap are displayed.
  logic unused_tap_hi;
  assign unused_tap_hi = ^{reg_2[31:DW], reg_3[31:DW]};

  assign src = sel_reg ? reg_3[DW-1:0] : reg_2[DW-1:0];

  // A new conversion is requested only from IDLE; changes seen mid-conversion
  // are picked up once the current one has finished.
  assign start = !conv_busy && (src != op_q);

  seg7_reg_display_bin2bcd #(.DW(DW)) u_bin2bcd (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .bin   (src),
    .bcd   (bcd),
    .op    (op_q),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  // Latch the finished decimal digits while the converter is in DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         dec_q <= '0;
    else if (conv_done) dec_q <= bcd;
  end

  // Refresh counter; the digit index advances on its terminal count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == RC_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + RC_W'(1);
    end
  end

  assign hex_val = 16'(op_q);

  // Leading-zero blanking: a digit blanks while it and every higher digit are 0.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (dec_q[15:12] == 4'd0);
    blank_mask[2] = blank_mask[3] && (dec_q[11:8] == 4'd0);
    blank_mask[1] = blank_mask[2] && (dec_q[7:4] == 4'd0);
  end

  // Glyph for the digit currently being scanned.
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
    if (hex_mode)
      seg_d = hex_glyph(hex_val[{idx_q, 2'b00} +: 4]);
    else if (dec_q[19:16] != 4'd0)
      seg_d = SEG_DASH;
    else if (blank_mask[idx_q])
      seg_d = SEG_BLANK;
    else
      seg_d = hex_glyph(dec_q[{idx_q, 2'b00} +: 4]);
  end

  // Anode and segment outputs share one register stage so they always change together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule

// File: tb/tb_seg7_reg_display.sv
// Directed bench for seg7_reg_display with a fast refresh divider.
module tb_seg7_reg_display;

  logic        CLK;
  logic        RST_N;
  logic [31:0] reg_2;
  logic [31:0] reg_3;
  logic        sel_reg;
  logic        hex_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  seg7_reg_display #(.REFRESH_DIV(4), .DW(16)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .reg_2    (reg_2),
    .reg_3    (reg_3),
    .sel_reg  (sel_reg),
    .hex_mode (hex_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Collect the glyph shown on each digit over one full scan, then compare.
  // exp packs {digit3, digit2, digit1, digit0}.
  task automatic check_digits(input string tag, input logic [27:0] exp);
    logic [27:0] got;
    got = 'x;
    @(negedge CLK);
    repeat (16) begin
      @(negedge CLK);
      case (an)
        4'b1110: got[6:0]   = seg;
        4'b1101: got[13:7]  = seg;
        4'b1011: got[20:14] = seg;
        4'b0111: got[27:21] = seg;
        default: ;
      endcase
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_digit%0d", tag, k), 32'(got[7*k +: 7]), 32'(exp[7*k +: 7]));
  endtask

  // Step at least one cycle, then wait (bounded) for the converter to go idle.
  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int         busy_len;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [3:0] one;

    one      = 4'b0001;
    RST_N    = 1'b0;
    reg_2    = 32'h0;
    reg_3    = 32'h0;
    sel_reg  = 1'b0;
    hex_mode = 1'b0;

    // 1. Reset state, then release: only digit0 shows '0'.
    repeat (3) @(negedge CLK);
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_dp",   32'(dp),   32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    RST_N = 1'b1;

    // 2. Scan: each anode active for exactly 4 clocks, wrapping after digit 3.
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      exp_an  = ~(one << ((k / 4) % 4));
      exp_seg = ((k / 4) % 4 == 0) ? 7'h40 : 7'h7F;
      check($sformatf("scan_an_%0d", k),  32'(an),  32'(exp_an));
      check($sformatf("scan_seg_%0d", k), 32'(seg), 32'(exp_seg));
    end
    check_digits("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // 3. Decimal 1234 from reg_2: 18-cycle busy window, then "1234".
    reg_2 = 32'h0000_04D2;
    busy_len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy) busy_len++;
      else if (busy_len != 0) break;
    end
    check("dec_busy_len", 32'(busy_len), 32'd18);
    check_digits("dec1234", {7'h79, 7'h24, 7'h30, 7'h19});

    // 4. Hex BEEF from reg_3; upper half of the tap ignored.
    sel_reg  = 1'b1;
    hex_mode = 1'b1;
    reg_3    = 32'h1234_BEEF;
    wait_idle("hex");
    check_digits("hexBEEF", {7'h03, 7'h06, 7'h06, 7'h0E});

    // 5. 10000 overflows four digits; a change mid-SHIFT waits its turn.
    sel_reg  = 1'b0;
    hex_mode = 1'b0;
    reg_2    = 32'd10000;
    repeat (6) @(negedge CLK);
    check("ovf_busy_mid", 32'(busy), 32'h1);
    reg_2 = 32'd7;
    wait_idle("ovf");
    @(negedge CLK);
    check("ovf_restart_busy", 32'(busy), 32'h1);
    check_digits("ovf_dash", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    wait_idle("seven");
    check_digits("dec7", {7'h7F, 7'h7F, 7'h7F, 7'h78});

    // 6. Reset during SHIFT aborts at once; release restarts on the current src.
    reg_2 = 32'd99;
    repeat (5) @(negedge CLK);
    check("abort_busy_before", 32'(busy), 32'h1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_an",   32'(an),   32'hF);
    check("abort_seg",  32'(seg),  32'h7F);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("abort_restart_busy", 32'(busy), 32'h1);
    wait_idle("dec99");
    check_digits("dec99", {7'h7F, 7'h7F, 7'h10, 7'h10});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
